// File: rtl/uart_tx_serializer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer_if
//  Purpose  : valid/ready byte stream feeding the UART transmitter.
//  Signals  : tx_data  [7:0] byte offered by the producer
//             tx_valid       producer offers tx_data
//             tx_ready       transmitter FIFO can accept a byte
//  Modports : master (producer), slave (transmitter)
//  Revision : 1.0  initial release
// ============================================================================
interface uart_tx_serializer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_serializer
//  Purpose  : Buffered UART transmitter. Bytes from a valid/ready stream are
//             queued in a FIFO and sent LSB first as 8N1 frames (8E1 when the
//             macro UART_TX_PARITY_EN is defined).
//  Params   : CLKS_PER_BIT  clock cycles per serial bit (>= 4)
//             FIFO_DEPTH    byte FIFO depth (power of two, >= 2)
//  Ports    : fpga_clk      system clock, rising edge
//             fpga_rst      asynchronous active-high reset
//             tx_if         slave side of the byte stream (data/valid/ready)
//             tx            registered serial line, idle high
//             busy          frame on the line or FIFO non-empty
//             fifo_count    bytes queued, excluding the frame in flight
//  Macro    : UART_TX_PARITY_EN  adds an even parity bit before the stop bit
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 100,
    parameter int FIFO_DEPTH   = 16
) (
    input  wire logic                        fpga_clk,
    input  wire logic                        fpga_rst,
    uart_tx_serializer_if.slave              tx_if,
    output logic                             tx,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

    localparam int                  c_aw       = $clog2(FIFO_DEPTH);
    localparam int                  c_cw       = $clog2(CLKS_PER_BIT);
    localparam logic [c_cw-1:0]     c_cnt_last = c_cw'(CLKS_PER_BIT - 1);
    localparam logic [c_aw:0]       c_full     = (c_aw + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic [7:0]      w_rd_data;

    assign w_ready   = (r_count != c_full);
    assign w_empty   = (r_count == '0);
    assign w_push    = tx_if.tx_valid && w_ready;
    assign w_rd_data = r_mem[r_rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge fpga_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    // Pointers are exactly c_aw bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_cw-1:0] r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      w_shift_nxt;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_bit_end;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    assign w_bit_end = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_shift_nxt = r_shift;
        w_tx_nxt    = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Popping on the last stop cycle makes frames gapless.
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_pop) w_shift_nxt = w_rd_data;

        // The line register is loaded with the level of the state being
        // entered, so tx changes on the same edge as the state.
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nxt = r_parity;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            // Every state change other than leaving IDLE happens at a bit
            // end, so clearing on bit end covers all transitions.
            if (r_state == S_IDLE || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end
            // Index wraps 7 -> 0 as the last data bit completes.
            if (r_state == S_DATA && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge fpga_clk or posedge fpga_rst) begin
        if (fpga_rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_rd_data;
        end
    end
`endif

    assign tx             = r_tx;
    assign tx_if.tx_ready = w_ready;
    assign busy           = (r_state != S_IDLE) || !w_empty;
    assign fifo_count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_serializer
//  Purpose  : Randomised self-checking bench for uart_tx_serializer. A queue
//             based frame model predicts tx, busy, fifo_count and tx_ready
//             every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int c_frame_bits = 11;
`else
    localparam int c_frame_bits = 10;
`endif
    localparam int c_frame_cyc = c_frame_bits * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_serializer_if u_if ();

    uart_tx_serializer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) u_dut (
        .fpga_clk   (clk),
        .fpga_rst   (rst),
        .tx_if      (u_if.slave),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: bytes waiting, plus the frame currently on the line as a bit
    // vector and the cycle offset into it.
    logic [7:0]  m_q[$];
    logic [10:0] m_frame;
    int          m_pos;
    bit          m_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
    endtask

    task automatic model_step();
        bit do_push;
        bit do_pop;
        do_push = u_if.tx_valid && (m_q.size() != DEPTH);
        do_pop  = (m_q.size() != 0) && (!m_active || m_pos == c_frame_cyc - 1);
        if (m_active) begin
            if (m_pos == c_frame_cyc - 1) m_active = 1'b0;
            else                          m_pos++;
        end
        if (do_pop) begin
            logic [7:0] b;
            b          = m_q.pop_front();
            m_frame    = '1;
            m_frame[0] = 1'b0;
            m_frame[8:1] = b;
`ifdef UART_TX_PARITY_EN
            m_frame[9] = ^b;
`endif
            m_pos    = 0;
            m_active = 1'b1;
        end
        if (do_push) m_q.push_back(u_if.tx_data);
    endtask

    task automatic check_outputs();
        logic exp_tx;
        exp_tx = m_active ? m_frame[m_pos / CPB] : 1'b1;
        check("tx",         32'(tx),             32'(exp_tx));
        check("fifo_count", 32'(fifo_count),     32'(m_q.size()));
        check("busy",       32'(busy),           32'(m_active || m_q.size() != 0));
        check("tx_ready",   32'(u_if.tx_ready),  32'(m_q.size() != DEPTH));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [7:0] b);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = b;
        tick();
        u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((m_active || m_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(n >= budget), 32'(0));
    endtask

    // Sends one byte while idle and measures start-bit-to-busy-fall time.
    task automatic frame_len(input logic [7:0] b);
        int n;
        send(b);
        tick();
        check("start_bit", 32'(tx), 32'(0));
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        check("frame_cycles", 32'(n), 32'(c_frame_cyc));
    endtask

    initial begin
        int  guard;
        bit  saw_full;
        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;
        model_reset();

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Single byte, then length of the frame
        frame_len(8'h55);
        repeat (3) tick();

        // Burst of three bytes on consecutive cycles
        u_if.tx_valid = 1'b1;
        u_if.tx_data = 8'hA5; tick();
        u_if.tx_data = 8'h00; tick();
        u_if.tx_data = 8'hFF; tick();
        u_if.tx_valid = 1'b0;
        wait_idle(500);

        // Full FIFO with incrementing data
        saw_full = 1'b0;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'h00;
        for (int i = 0; i < 1200; i++) begin
            bit acc;
            acc = (m_q.size() != DEPTH);
            tick();
            if (fifo_count == 5'd16) saw_full = 1'b1;
            if (acc) u_if.tx_data = u_if.tx_data + 8'd1;
        end
        u_if.tx_valid = 1'b0;
        check("full_reached", 32'(saw_full), 32'(1));
        wait_idle(DEPTH * c_frame_cyc + 100);

        // Reset during data bit 3 of 0x3C with more bytes queued
        u_if.tx_valid = 1'b1;
        u_if.tx_data = 8'h3C; tick();
        u_if.tx_data = 8'h11; tick();
        u_if.tx_data = 8'h22; tick();
        u_if.tx_valid = 1'b0;
        guard = 0;
        while (!(m_active && (m_pos / CPB) == 4) && guard < 100) begin
            tick();
            guard++;
        end
        check("reach_bit3", 32'(guard >= 100), 32'(0));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();
        send(8'h81);
        wait_idle(200);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            u_if.tx_valid = ($urandom_range(0, 5) == 0);
            u_if.tx_data  = 8'($urandom);
            tick();
        end
        u_if.tx_valid = 1'b0;
        wait_idle(DEPTH * c_frame_cyc + 100);

`ifdef UART_TX_PARITY_EN
        frame_len(8'h07);
        repeat (2) tick();
        frame_len(8'h03);
        repeat (2) tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
